// File: rtl/rv32m_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv32m_muldiv_pkg
// Brief   : RV32M funct3 op encodings and the FSM state type for the MDU.
// Revision: 1.0
// ============================================================================
package rv32m_muldiv_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  function automatic logic src1_is_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic src2_is_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32m_div_core.sv
`default_nettype none
// ============================================================================
// Module  : rv32m_div_core
// Brief   : Unsigned iterative restoring divider, one quotient bit per cycle.
// Revision: 1.0
// ============================================================================
module rv32m_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int unsigned   CW         = $clog2(XLEN);
  localparam logic [CW-1:0] c_CNT_LAST = CW'(XLEN - 1);

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvsr;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;

  logic [XLEN-1:0] w_rem_in;
  logic [XLEN-1:0] w_quo_in;
  logic [XLEN-1:0] w_dvsr;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;

  // The start cycle already performs the first iteration on the raw inputs,
  // so the result is ready XLEN edges after start.
  assign w_rem_in = i_start ? '0         : r_rem;
  assign w_quo_in = i_start ? i_dividend : r_quo;
  assign w_dvsr   = i_start ? i_divisor  : r_dvsr;

  assign w_shift  = {w_rem_in, w_quo_in[XLEN-1]};
  assign w_diff   = w_shift - {1'b0, w_dvsr};
  assign w_ge     = ~w_diff[XLEN];
  assign w_rem_nx = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nx = {w_quo_in[XLEN-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvsr <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_rem  <= w_rem_nx;
      r_quo  <= w_quo_nx;
      r_dvsr <= i_divisor;
      r_cnt  <= CW'(1);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      if (r_cnt == c_CNT_LAST) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/rv32m_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : rv32m_muldiv
// Brief   : RV32M multiply/divide unit: shift-add multiplier, restoring divider.
// Revision: 1.0
// ============================================================================
module rv32m_muldiv
  import rv32m_muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned     CW         = $clog2(XLEN);
  localparam logic [CW-1:0]   c_CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] c_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic [XLEN-1:0] r_result;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic            r_neg_p;
  logic            r_neg_r;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_mcand;

  logic            w_accept;
  logic            w_is_div;
  logic            w_neg1;
  logic            w_neg2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_fast_en;
  logic [XLEN-1:0] w_fast_res;

  logic            w_mul_step;
  logic [XLEN-1:0] w_hi_in;
  logic [XLEN-1:0] w_lo_in;
  logic [XLEN-1:0] w_mc;
  logic [XLEN:0]   w_sum;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0] w_mul_res;

  logic            w_div_start;
  logic            w_div_done;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_div_res;

  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_is_div  = op[2];
  assign w_neg1    = src1_is_signed(op) & src1[XLEN-1];
  assign w_neg2    = src2_is_signed(op) & src2[XLEN-1];
  assign w_mag1    = w_neg1 ? -src1 : src1;
  assign w_mag2    = w_neg2 ? -src2 : src2;
  assign w_div0    = (src2 == '0);
  assign w_ovf     = ((op == MDU_DIV) || (op == MDU_REM)) && (src1 == c_INT_MIN) && (src2 == '1);
  assign w_special = w_is_div && (w_div0 || w_ovf);
  assign w_fast_en = FAST_MUL && !w_is_div;

  always_comb begin
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = op[1] ? src1 : '1;
    end else if (op == MDU_DIV) begin
      w_special_res = src1;
    end
  end

  if (FAST_MUL) begin : g_fast_mul
    logic [2*XLEN-1:0] w_fprod;
    logic [2*XLEN-1:0] w_fprod_fix;
    assign w_fprod     = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
    assign w_fprod_fix = (w_neg1 ^ w_neg2) ? -w_fprod : w_fprod;
    assign w_fast_res  = (op == MDU_MUL) ? w_fprod_fix[XLEN-1:0] : w_fprod_fix[2*XLEN-1:XLEN];
  end else begin : g_iter_mul
    assign w_fast_res = '0;
  end

  // Shift-add step: {hi,lo} holds the partial product with the multiplier
  // draining out of lo. The accepting edge performs the first step.
  assign w_mul_step = (w_accept && !w_is_div && !w_fast_en) ||
                      ((r_state == ST_CALC) && !r_op[2] && (r_cnt != c_CNT_LAST));
  assign w_hi_in    = w_accept ? '0     : r_hi;
  assign w_lo_in    = w_accept ? w_mag2 : r_lo;
  assign w_mc       = w_accept ? w_mag1 : r_mcand;
  assign w_sum      = {1'b0, w_hi_in} + (w_lo_in[0] ? {1'b0, w_mc} : {(XLEN+1){1'b0}});

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_p ? -w_prod : w_prod;
  assign w_mul_res  = (r_op == MDU_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];

  assign w_div_start = w_accept && w_is_div && !w_special;

  rv32m_div_core #(
    .XLEN (XLEN)
  ) u_div_core (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_div_start),
    .i_dividend  (w_mag1),
    .i_divisor   (w_mag2),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  always_comb begin
    w_div_res = '0;
    if (r_op[1]) begin
      w_div_res = r_neg_r ? -w_rem : w_rem;
    end else begin
      w_div_res = r_neg_p ? -w_quo : w_quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_neg_p     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_mcand     <= '0;
    end else begin
      if (w_mul_step) begin
        r_hi    <= w_sum[XLEN:1];
        r_lo    <= {w_sum[0], w_lo_in[XLEN-1:1]};
        r_mcand <= w_mc;
      end
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op       <= op;
            r_neg_p    <= w_neg1 ^ w_neg2;
            r_neg_r    <= w_neg1;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_special) begin
              r_result    <= w_special_res;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else if (w_fast_en) begin
              r_result    <= w_fast_res;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (r_op[2] ? w_div_done : (r_cnt == c_CNT_LAST)) begin
            r_result    <= r_op[2] ? w_div_res : w_mul_res;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rv32m_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv32m_muldiv
// Brief   : Scoreboard bench for rv32m_muldiv (iterative and fast-multiply).
// Revision: 1.0
// ============================================================================
module tb_rv32m_muldiv;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
  localparam int LAT_IT = 33;
  localparam int LAT_SP = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
  logic [2:0]  op = '0;
  logic [31:0] src1 = '0, src2 = '0, result;

  logic        f_in_valid = 1'b0, f_in_ready, f_out_valid, f_busy;
  logic [2:0]  f_op = '0;
  logic [31:0] f_src1 = '0, f_src2 = '0, f_result;

  always #5 clk = ~clk;

  rv32m_muldiv #(.XLEN(32), .FAST_MUL(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  rv32m_muldiv #(.XLEN(32), .FAST_MUL(1'b1)) u_fast (
    .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready), .op(f_op),
    .src1(f_src1), .src2(f_src2), .out_valid(f_out_valid), .out_ready(1'b1),
    .result(f_result), .busy(f_busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  string       name_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flush_sb();
    exp_q.delete(); lat_q.delete(); acc_q.delete(); name_q.delete();
  endtask

  // Monitor: latency on the first out_valid cycle, hold checks under
  // backpressure, result compare on the handshake.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected out_valid: result %h with empty scoreboard", result);
      end else if (out_valid) begin
        if (!prev_valid) chk({name_q[0], " latency"}, 32'(cyc - acc_q[0]), 32'(lat_q[0]));
        if (!out_ready) chk({name_q[0], " held"}, result, exp_q[0]);
        if (out_ready) begin
          chk(name_q[0], result, exp_q[0]);
          void'(exp_q.pop_front()); void'(lat_q.pop_front());
          void'(acc_q.pop_front()); void'(name_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int lat, input string nm);
    int g = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; src1 = a; src2 = b;
    while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
    if (!in_ready) begin
      n_checks++; n_errors++;
      $display("FAIL %s accept timeout: in_ready %b required 1", nm, in_ready);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e); lat_q.push_back(lat); acc_q.push_back(cyc); name_q.push_back(nm);
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; src1 = 32'hDEAD_BEEF; src2 = 32'h0BAD_F00D;
  endtask

  task automatic wait_drain(input string nm);
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin @(posedge clk); #1; g++; end
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s completion timeout: %0d pending, required 0", nm, exp_q.size());
      flush_sb();
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e, input int lat, input string nm);
    issue(o, a, b, e, lat, nm);
    wait_drain(nm);
  endtask

  task automatic fast_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input string nm);
    @(posedge clk); #1;
    f_in_valid = 1'b1; f_op = o; f_src1 = a; f_src2 = b;
    chk({nm, " in_ready"}, 32'(f_in_ready), 32'd1);
    @(posedge clk); #1;
    f_in_valid = 1'b0;
    chk({nm, " out_valid lat1"}, 32'(f_out_valid), 32'd1);
    chk({nm, " busy"}, 32'(f_busy), 32'd1);
    chk(nm, f_result, e);
    @(posedge clk); #1;
    chk({nm, " back to idle"}, 32'(f_in_ready), 32'd1);
  endtask

  initial begin
    int g;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;

    run(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_IT, "MUL 7*-3");
    run(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_IT, "MULH min*min");
    run(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_IT, "MULHU max*max");
    run(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_IT, "MULHSU -1*max");
    run(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_IT, "DIV -7/2");
    run(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_IT, "REM -7/2");
    run(OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_IT, "DIV 7/-2");
    run(OP_DIVU,   32'd100,       32'd7,         32'd14,        LAT_IT, "DIVU 100/7");
    run(OP_REMU,   32'd100,       32'd7,         32'd2,         LAT_IT, "REMU 100/7");
    run(OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_IT, "DIVU min/max");
    run(OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_IT, "REMU min/max");
    run(OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SP, "DIVU 5/0");
    run(OP_REM,    32'd5,         32'd0,         32'd5,         LAT_SP, "REM 5/0");
    run(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP, "DIV overflow");
    run(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SP, "REM overflow");

    // Backpressure: result held five cycles, in_valid pulses ignored.
    out_ready = 1'b0;
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_IT, "MULHU stalled");
    g = 0;
    while (!out_valid && g < 100) begin @(posedge clk); #1; g++; end
    for (int i = 0; i < 5; i++) begin
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall busy", 32'(busy), 32'd1);
      in_valid = (i % 2 == 0); op = OP_MUL; src1 = 32'd3; src2 = 32'd4;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post-handshake in_ready", 32'(in_ready), 32'd1);
    chk("post-handshake out_valid", 32'(out_valid), 32'd0);
    chk("post-handshake busy", 32'(busy), 32'd0);
    wait_drain("MULHU stalled");

    // Reset in the middle of a division discards it.
    issue(OP_DIV, 32'd1000, 32'd3, 32'd333, LAT_IT, "DIV aborted");
    repeat (10) begin @(posedge clk); #1; end
    chk("mid-op busy", 32'(busy), 32'd1);
    rst = 1'b1;
    flush_sb();
    @(posedge clk); #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    rst = 1'b0;
    run(OP_MUL, 32'd3, 32'd4, 32'd12, LAT_IT, "MUL 3*4 after reset");

    fast_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "fast MUL 7*-3");
    fast_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "fast MULH min*min");
    fast_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "fast MULHSU -1*max");

    repeat (3) @(posedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
